// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction field widths, bit positions and the NOP word.
// Decode and the IF/ID register both slice instructions using these constants.
package cpu_pkg;

    localparam int DATA_W   = 32;
    localparam int OPCODE_W = 6;
    localparam int REG_W    = 5;
    localparam int IMM_W    = 16;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int RS_MSB     = 25;
    localparam int RS_LSB     = 21;
    localparam int RT_MSB     = 20;
    localparam int RT_LSB     = 16;
    localparam int RD_MSB     = 15;
    localparam int RD_LSB     = 11;
    localparam int IMM_MSB    = 15;
    localparam int IMM_LSB    = 0;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [5:0] {
        OP_RTYPE = 6'h00,
        OP_J     = 6'h02,
        OP_BEQ   = 6'h04,
        OP_ADDI  = 6'h08,
        OP_LW    = 6'h23,
        OP_SW    = 6'h2B
    } opcode_e;

endpackage

// File: rtl/pipe_skid_buf.sv
// Two-entry (main + skid) valid/ready pipeline buffer with flush and registered outputs.
// When the main entry empties, the EMPTY_MASK bits of its payload are forced to EMPTY_DATA.
module pipe_skid_buf #(
    parameter int           W          = 64,
    parameter logic [W-1:0] RST_DATA   = '0,
    parameter logic [W-1:0] EMPTY_MASK = '0,
    parameter logic [W-1:0] EMPTY_DATA = '0
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [W-1:0] i_data,
    input  logic         i_flush,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [W-1:0] o_data
);

    logic         m_valid_r, s_valid_r, ready_r;
    logic [W-1:0] m_data_r, s_data_r;
    logic         m_valid_s, s_valid_s;
    logic [W-1:0] m_data_s, s_data_s;
    logic         accept_s, emit_s;

    function automatic logic [W-1:0] empty_fill(input logic [W-1:0] d);
        return (d & ~EMPTY_MASK) | (EMPTY_DATA & EMPTY_MASK);
    endfunction

    // Next-state selection for the main and skid entries.
    always_comb begin
        accept_s  = i_valid && ready_r;
        emit_s    = m_valid_r && i_ready;
        m_valid_s = m_valid_r;
        m_data_s  = m_data_r;
        s_valid_s = s_valid_r;
        s_data_s  = s_data_r;
        if (i_flush) begin
            m_valid_s = 1'b0;
            m_data_s  = empty_fill(m_data_r);
            s_valid_s = 1'b0;
        end else if (!m_valid_r || (emit_s && !s_valid_r)) begin
            if (accept_s) begin
                m_valid_s = 1'b1;
                m_data_s  = i_data;
            end else begin
                m_valid_s = 1'b0;
                m_data_s  = empty_fill(m_data_r);
            end
        end else if (emit_s) begin
            // Skid drains into main; ready_r was low so accept_s is normally 0 here.
            m_valid_s = 1'b1;
            m_data_s  = s_data_r;
            s_valid_s = accept_s;
            if (accept_s) begin
                s_data_s = i_data;
            end else begin
                s_data_s = s_data_r;
            end
        end else begin
            if (accept_s) begin
                s_valid_s = 1'b1;
                s_data_s  = i_data;
            end else begin
                s_valid_s = s_valid_r;
                s_data_s  = s_data_r;
            end
        end
    end

    // Entry storage and registered ready.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_valid_r <= 1'b0;
            s_valid_r <= 1'b0;
            m_data_r  <= RST_DATA;
            s_data_r  <= RST_DATA;
            ready_r   <= 1'b1;
        end else begin
            m_valid_r <= m_valid_s;
            s_valid_r <= s_valid_s;
            m_data_r  <= m_data_s;
            s_data_r  <= s_data_s;
            ready_r   <= !s_valid_s;
        end
    end

    assign o_valid = m_valid_r;
    assign o_data  = m_data_r;
    assign o_ready = ready_r;

endmodule

// File: rtl/if_id_pipe_reg.sv
// IF/ID pipeline register: skid-buffered {pc4, instr} plus decode field slicing.
// Optional macro IFID_STALL_CNT_EN adds a saturating decode-stall cycle counter (o_stall_cnt).
module if_id_pipe_reg
    import cpu_pkg::*;
#(
    parameter int                 DATA_W    = 32,
    parameter logic [DATA_W-1:0]  NOP_INSTR = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic [DATA_W-1:0]   i_pc4,
    input  logic [DATA_W-1:0]   i_instr,
    input  logic                i_flush,
    output logic                o_valid,
    input  logic                i_ready,
    output logic [DATA_W-1:0]   o_pc4,
    output logic [DATA_W-1:0]   o_instr,
    output logic [OPCODE_W-1:0] o_opcode,
    output logic [REG_W-1:0]    o_rs,
    output logic [REG_W-1:0]    o_rt,
    output logic [REG_W-1:0]    o_rd,
`ifdef IFID_STALL_CNT_EN
    output logic [31:0]         o_stall_cnt,
`endif
    output logic [IMM_W-1:0]    o_imm16
);

    localparam int PW = 2 * DATA_W;
    // pc4 survives emptying/flush; only the instruction half reverts to NOP.
    localparam logic [PW-1:0] RST_PAYLOAD = {{DATA_W{1'b0}}, NOP_INSTR};
    localparam logic [PW-1:0] EMPTY_MASK  = {{DATA_W{1'b0}}, {DATA_W{1'b1}}};
    localparam logic [PW-1:0] EMPTY_DATA  = {{DATA_W{1'b0}}, NOP_INSTR};

    logic [PW-1:0] payload_s;

    pipe_skid_buf #(
        .W          (PW),
        .RST_DATA   (RST_PAYLOAD),
        .EMPTY_MASK (EMPTY_MASK),
        .EMPTY_DATA (EMPTY_DATA)
    ) u_skid (
        .clk     (clk),
        .reset_n (reset_n),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_data  ({i_pc4, i_instr}),
        .i_flush (i_flush),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_data  (payload_s)
    );

    assign o_pc4    = payload_s[PW-1:DATA_W];
    assign o_instr  = payload_s[DATA_W-1:0];
    assign o_opcode = o_instr[OPCODE_MSB:OPCODE_LSB];
    assign o_rs     = o_instr[RS_MSB:RS_LSB];
    assign o_rt     = o_instr[RT_MSB:RT_LSB];
    assign o_rd     = o_instr[RD_MSB:RD_LSB];
    assign o_imm16  = o_instr[IMM_MSB:IMM_LSB];

`ifdef IFID_STALL_CNT_EN
    logic [31:0] stall_cnt_r;

    // Saturating count of cycles where decode holds a valid entry; only reset clears it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_r <= 32'h0000_0000;
        end else if (o_valid && !i_ready && (stall_cnt_r != 32'hFFFF_FFFF)) begin
            stall_cnt_r <= stall_cnt_r + 32'd1;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign o_stall_cnt = stall_cnt_r;
`endif

endmodule

// File: tb/tb_if_id_pipe_reg.sv
// Scoreboard bench for if_id_pipe_reg: driver pushes accepted {pc4,instr}, monitor pops on emit.
// Define IFID_STALL_CNT_EN to also exercise o_stall_cnt.
module tb_if_id_pipe_reg;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        i_valid, o_ready, i_flush, o_valid, i_ready;
    logic [31:0] i_pc4, i_instr, o_pc4, o_instr;
    logic [5:0]  o_opcode;
    logic [4:0]  o_rs, o_rt, o_rd;
    logic [15:0] o_imm16;
`ifdef IFID_STALL_CNT_EN
    logic [31:0] o_stall_cnt;
`endif

    int checks   = 0;
    int failures = 0;
    logic [63:0] sb_q[$];

    if_id_pipe_reg dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_pc4    (i_pc4),
        .i_instr  (i_instr),
        .i_flush  (i_flush),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_pc4    (o_pc4),
        .o_instr  (o_instr),
        .o_opcode (o_opcode),
        .o_rs     (o_rs),
        .o_rt     (o_rt),
        .o_rd     (o_rd),
`ifdef IFID_STALL_CNT_EN
        .o_stall_cnt (o_stall_cnt),
`endif
        .o_imm16  (o_imm16)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] pc4, input logic [31:0] instr);
        int  n;
        bit  acc;
        i_valid = 1'b1;
        i_pc4   = pc4;
        i_instr = instr;
        n   = 0;
        acc = 1'b0;
        while (!acc && n < 20) begin
            acc = o_ready;
            step();
            n++;
        end
        if (!acc) begin
            failures++;
            $display("FAIL send_timeout: instr %0h not accepted within 20 cycles", instr);
        end
        i_valid = 1'b0;
    endtask

    // Monitor: compares every emitted entry against the oldest accepted one.
    always @(negedge clk) begin
        logic [63:0] exp;
        if (!reset_n || i_flush) begin
            sb_q.delete();
        end else begin
            if (o_valid && i_ready) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_emit: got instr %0h with empty scoreboard", o_instr);
                end else begin
                    exp = sb_q.pop_front();
                    check("emit_pc4",    {32'h0, o_pc4},   {32'h0, exp[63:32]});
                    check("emit_instr",  {32'h0, o_instr}, {32'h0, exp[31:0]});
                    check("emit_opcode", {58'h0, o_opcode}, {58'h0, exp[31:26]});
                    check("emit_imm16",  {48'h0, o_imm16},  {48'h0, exp[15:0]});
                end
            end
            if (i_valid && o_ready) begin
                sb_q.push_back({i_pc4, i_instr});
            end
        end
    end

    initial begin
        reset_n = 1'b0;
        i_flush = 1'b0;
        i_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            i_valid = 1'($urandom_range(0, 1));
            i_ready = 1'($urandom_range(0, 1));
            i_flush = 1'($urandom_range(0, 1));
            i_pc4   = $urandom;
            i_instr = $urandom;
            step();
            check("rst_valid", {63'h0, o_valid}, 64'h0);
            check("rst_ready", {63'h0, o_ready}, 64'h1);
            check("rst_instr", {32'h0, o_instr}, 64'h0);
            check("rst_imm16", {48'h0, o_imm16}, 64'h0);
        end
        i_valid = 1'b0;
        i_flush = 1'b0;
        i_ready = 1'b1;
        reset_n = 1'b1;
        step();
        step();
        check("idle_valid", {63'h0, o_valid}, 64'h0);
        check("idle_ready", {63'h0, o_ready}, 64'h1);
        check("idle_pc4",   {32'h0, o_pc4},   64'h0);

        // Streaming
        send(32'h0000_0004, 32'h2008_FFFC);
        check("s1_valid",  {63'h0, o_valid},  64'h1);
        check("s1_opcode", {58'h0, o_opcode}, 64'h08);
        check("s1_rt",     {59'h0, o_rt},     64'd8);
        check("s1_imm16",  {48'h0, o_imm16},  64'hFFFC);
        send(32'h0000_0008, 32'h0109_5020);
        check("s2_instr", {32'h0, o_instr}, 64'h0109_5020);
        check("s2_rd",    {59'h0, o_rd},    64'd10);
        check("s2_rs",    {59'h0, o_rs},    64'd8);
        step();
        check("s_empty_valid", {63'h0, o_valid}, 64'h0);
        check("s_empty_nop",   {32'h0, o_instr}, 64'h0);
        check("s_keep_pc4",    {32'h0, o_pc4},   64'h8);

        // Stall: A held, B into skid, C blocked
        i_ready = 1'b0;
        send(32'h0000_0010, 32'h8C43_0004);
        send(32'h0000_0014, 32'hAC64_0008);
        i_valid = 1'b1;
        i_pc4   = 32'h0000_0018;
        i_instr = 32'h0085_3022;
        check("stall_ready", {63'h0, o_ready}, 64'h0);
        check("stall_hold",  {32'h0, o_instr}, 64'h8C43_0004);
        step();
        step();
        check("stall_hold2", {32'h0, o_instr}, 64'h8C43_0004);
        check("stall_ready2", {63'h0, o_ready}, 64'h0);
        i_ready = 1'b1;
        send(32'h0000_0018, 32'h0085_3022);
        for (int i = 0; i < 3; i++) step();
        check("drain_empty", {63'h0, o_valid}, 64'h0);
        check("sb_empty", 64'(sb_q.size()), 64'h0);

        // Flush discards the instruction accepted on the same edge
        i_valid = 1'b1;
        i_pc4   = 32'h0000_0040;
        i_instr = 32'h2010_0001;
        i_flush = 1'b1;
        step();
        i_flush = 1'b0;
        i_valid = 1'b0;
        check("flacc_valid", {63'h0, o_valid}, 64'h0);

        // Flush during stall with M and S full, D presented
        i_ready = 1'b0;
        send(32'h0000_0020, 32'h2011_0005);
        send(32'h0000_0024, 32'h2012_0006);
        i_valid = 1'b1;
        i_pc4   = 32'h0000_0028;
        i_instr = 32'h2013_0007;
        i_flush = 1'b1;
        step();
        i_flush = 1'b0;
        i_valid = 1'b0;
        check("fl_valid", {63'h0, o_valid}, 64'h0);
        check("fl_nop",   {32'h0, o_instr}, 64'h0);
        check("fl_ready", {63'h0, o_ready}, 64'h1);
        check("fl_pc4",   {32'h0, o_pc4},   64'h20);
        i_ready = 1'b1;
        for (int i = 0; i < 3; i++) step();
        check("fl_no_d", {63'h0, o_valid}, 64'h0);

        // Async reset mid-stream
        i_ready = 1'b0;
        send(32'h0000_0030, 32'h2014_0009);
        check("ar_pre_valid", {63'h0, o_valid}, 64'h1);
        #2;
        reset_n = 1'b0;
        #1;
        check("ar_valid", {63'h0, o_valid}, 64'h0);
        check("ar_instr", {32'h0, o_instr}, 64'h0);
        check("ar_ready", {63'h0, o_ready}, 64'h1);
        check("ar_pc4",   {32'h0, o_pc4},   64'h0);
        step();
        #2;
        reset_n = 1'b1;
        step();
        i_ready = 1'b1;
        send(32'h0000_0034, 32'h2015_000A);
        check("ar_next_instr", {32'h0, o_instr}, 64'h2015_000A);
        step();
        step();
        check("ar_sb_empty", 64'(sb_q.size()), 64'h0);

`ifdef IFID_STALL_CNT_EN
        reset_n = 1'b0;
        #1;
        reset_n = 1'b1;
        step();
        check("cnt_rst", {32'h0, o_stall_cnt}, 64'h0);
        i_ready = 1'b0;
        send(32'h0000_0050, 32'h2016_000B);
        for (int i = 0; i < 5; i++) step();
        check("cnt_5", {32'h0, o_stall_cnt}, 64'd5);
        i_ready = 1'b1;
        i_flush = 1'b1;
        step();
        i_flush = 1'b0;
        check("cnt_flush_keep", {32'h0, o_stall_cnt}, 64'd5);
        i_ready = 1'b0;
        send(32'h0000_0054, 32'h2017_000C);
        step();
        step();
        check("cnt_7", {32'h0, o_stall_cnt}, 64'd7);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
